// File: rtl/oled_pkg.sv
// Shared constants for the OLED I2C transaction sequencer.
package oled_pkg;

    // Sequencer FSM states
    localparam logic [2:0] ST_PWRUP  = 3'd0;
    localparam logic [2:0] ST_GAP    = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_BUSY   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_IDLE   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    // Transaction kinds
    localparam logic [1:0] KIND_INIT = 2'd0;
    localparam logic [1:0] KIND_WIN  = 2'd1;
    localparam logic [1:0] KIND_DATA = 2'd2;

    // SSD1306 control bytes and bus identity
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;
    localparam logic [6:0] OLED_ID   = 7'h3C;

    // Payload length for a transaction kind: control byte plus its body
    function automatic logic [10:0] byteQnty(input logic [1:0] kind, input int initLen,
                                             input int winLen, input int fbBytes);
        int n;
        if (kind == KIND_INIT)     n = initLen + 1;
        else if (kind == KIND_WIN) n = winLen + 1;
        else                       n = fbBytes + 1;
        return 11'(n);
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 init script followed by the full-screen window-set commands.
module oled_init_rom #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);

    // Synchronous read; out-of-range addresses return 0
    always_ff @(posedge clk) begin
        case (int'(addr))
            0:  data <= 8'hAE;   // display off
            1:  data <= 8'hD5;   // clock divide
            2:  data <= 8'h80;
            3:  data <= 8'hA8;   // multiplex ratio
            4:  data <= 8'h3F;
            5:  data <= 8'hD3;   // display offset
            6:  data <= 8'h00;
            7:  data <= 8'h40;   // start line 0
            8:  data <= 8'h8D;   // charge pump
            9:  data <= 8'h14;
            10: data <= 8'h20;   // horizontal addressing
            11: data <= 8'h00;
            12: data <= 8'hA1;   // segment remap
            13: data <= 8'hC8;   // COM scan descending
            14: data <= 8'hDA;   // COM pins
            15: data <= 8'h12;
            16: data <= 8'h81;   // contrast
            17: data <= 8'hCF;
            18: data <= 8'hD9;   // precharge
            19: data <= 8'hF1;
            20: data <= 8'hDB;   // VCOMH
            21: data <= 8'h40;
            22: data <= 8'hA4;   // resume from RAM
            23: data <= 8'hA6;   // normal display
            24: data <= 8'hAF;   // display on
            25: data <= 8'h21;   // column range 0..127
            26: data <= 8'h00;
            27: data <= 8'h7F;
            28: data <= 8'h22;   // page range 0..7
            29: data <= 8'h00;
            30: data <= 8'h07;
            default: data <= 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_i2c_seq.sv
// Transaction sequencer feeding the i2cWR write engine on the OLED path.
//
//  state  | meaning
//  PWRUP  | post-reset wait before the first transaction
//  GAP    | bus free time between transactions
//  LAUNCH | oStart asserted until i2cWR reports activity
//  BUSY   | transaction on the bus, NACKs latched
//  CHECK  | one-cycle verdict: next kind, retry or fault
//  IDLE   | ready, waiting for a frame request
//  FAULT  | retries exhausted, left only by rst
module oled_i2c_seq #(
    parameter int INIT_LEN  = 25,
    parameter int WIN_LEN   = 6,
    parameter int FB_BYTES  = 1024,
    parameter int PWRUP_CYC = 1000,
    parameter int GAP_CYC   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iFrameReq,
    output logic [9:0]  oFbAddr,
    input  logic [7:0]  iFbData,
    output logic        oStart,
    output logic [10:0] oByteQnty,
    output logic [7:0]  oByteOut,
    input  logic [10:0] iByteCnt,
    input  logic        iAckErr,
    input  logic        iAction,
    output logic        oReady,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic        oFault
);
    import oled_pkg::*;

    localparam int ROM_AW  = $clog2(INIT_LEN + WIN_LEN);
    localparam int TMR_MAX = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    logic [2:0]       state, stateNext;
    logic [1:0]       kind, kindNext;
    logic [TMR_W-1:0] timer, timerNext;
    logic [RTY_W-1:0] retry, retryNext;
    logic             pending, pendingNext;
    logic             nack, nackNext;
    logic             actPrev;
    logic [10:0]      qntyNext;
    logic             readyNext, faultNext, doneNext;

    logic [10:0]       idxM1;
    logic [ROM_AW-1:0] romAddr;
    logic [7:0]        romData;
    logic              selZero, selData;

    // Start is dropped combinationally as soon as i2cWR picks it up
    assign oStart = (state == ST_LAUNCH) && !iAction;

    // Next-state and register update decisions
    always_comb begin
        stateNext   = state;
        kindNext    = kind;
        timerNext   = '0;
        retryNext   = retry;
        pendingNext = pending | (iFrameReq & (state != ST_IDLE) & (state != ST_FAULT));
        nackNext    = nack;
        qntyNext    = oByteQnty;
        readyNext   = oReady;
        faultNext   = oFault;
        doneNext    = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (timer == TMR_W'(PWRUP_CYC - 1)) begin
                    stateNext = ST_GAP;
                    kindNext  = KIND_INIT;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            ST_GAP: begin
                if (timer == TMR_W'(GAP_CYC - 1)) begin
                    stateNext = ST_LAUNCH;
                    nackNext  = 1'b0;
                    qntyNext  = byteQnty(kind, INIT_LEN, WIN_LEN, FB_BYTES);
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            ST_LAUNCH: begin
                if (iAction) stateNext = ST_BUSY;
            end
            ST_BUSY: begin
                nackNext = nack | iAckErr;
                if (actPrev && !iAction) stateNext = ST_CHECK;
            end
            ST_CHECK: begin
                if (!nack) begin
                    retryNext = '0;
                    case (kind)
                        KIND_INIT: begin
                            stateNext = ST_IDLE;
                            readyNext = 1'b1;
                        end
                        KIND_WIN: begin
                            stateNext = ST_GAP;
                            kindNext  = KIND_DATA;
                        end
                        default: begin
                            doneNext = 1'b1;
                            // A request arriving right now is served like a pending one
                            if (pending || iFrameReq) begin
                                stateNext   = ST_GAP;
                                kindNext    = KIND_WIN;
                                pendingNext = 1'b0;
                            end else begin
                                stateNext = ST_IDLE;
                            end
                        end
                    endcase
                end else if (retry < RTY_W'(MAX_RETRY)) begin
                    retryNext = retry + 1'b1;
                    stateNext = ST_GAP;
                end else begin
                    stateNext = ST_FAULT;
                    faultNext = 1'b1;
                end
            end
            ST_IDLE: begin
                if (pending || iFrameReq) begin
                    pendingNext = 1'b0;
                    stateNext   = ST_GAP;
                    kindNext    = KIND_WIN;
                end
            end
            ST_FAULT: ;
            default: stateNext = ST_PWRUP;
        endcase
    end

    // FSM, counters and status outputs; oBusy tracks the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PWRUP;
            kind       <= KIND_INIT;
            timer      <= '0;
            retry      <= '0;
            pending    <= 1'b0;
            nack       <= 1'b0;
            actPrev    <= 1'b0;
            oByteQnty  <= '0;
            oReady     <= 1'b0;
            oFault     <= 1'b0;
            oFrameDone <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            state      <= stateNext;
            kind       <= kindNext;
            timer      <= timerNext;
            retry      <= retryNext;
            pending    <= pendingNext;
            nack       <= nackNext;
            actPrev    <= iAction;
            oByteQnty  <= qntyNext;
            oReady     <= readyNext;
            oFault     <= faultNext;
            oFrameDone <= doneNext;
            oBusy      <= (stateNext != ST_IDLE) && (stateNext != ST_FAULT);
        end
    end

    // Index 0 is the control byte; index k reads entry k-1 of the selected source
    assign idxM1   = iByteCnt - 11'd1;
    assign romAddr = ROM_AW'((kind == KIND_INIT) ? idxM1 : idxM1 + 11'(INIT_LEN));
    assign oFbAddr = (iByteCnt == 11'd0) ? 10'd0 : idxM1[9:0];

    oled_init_rom #(.AW(ROM_AW)) uRom (
        .clk  (clk),
        .addr (romAddr),
        .data (romData)
    );

    // Byte mux: selection delayed to line up with ROM / framebuffer read data
    always_ff @(posedge clk) begin
        if (rst) begin
            selZero  <= 1'b0;
            selData  <= 1'b0;
            oByteOut <= 8'h00;
        end else begin
            selZero <= (iByteCnt == 11'd0);
            selData <= (kind == KIND_DATA);
            if (selZero) oByteOut <= selData ? CTRL_DATA : CTRL_CMD;
            else         oByteOut <= selData ? iFbData : romData;
        end
    end

endmodule

// File: tb/tb_oled_i2c_seq.sv
// Bench for oled_i2c_seq: behavioural i2cWR + slave with programmable NACK position, wire-byte scoreboard.
module tb_oled_i2c_seq;
    import oled_pkg::*;

    localparam int INIT_LEN  = 25;
    localparam int WIN_LEN   = 6;
    localparam int FB_BYTES  = 1024;
    localparam int PWRUP_CYC = 1000;
    localparam int GAP_CYC   = 16;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iFrameReq = 1'b0;
    logic [9:0]  oFbAddr;
    logic [7:0]  iFbData;
    logic        oStart;
    logic [10:0] oByteQnty;
    logic [7:0]  oByteOut;
    logic [10:0] mCnt;
    logic        mErr, mAct;
    logic        oReady, oBusy, oFrameDone, oFault;

    always #5 clk = ~clk;

    oled_i2c_seq #(
        .INIT_LEN(INIT_LEN), .WIN_LEN(WIN_LEN), .FB_BYTES(FB_BYTES),
        .PWRUP_CYC(PWRUP_CYC), .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .iFrameReq(iFrameReq), .oFbAddr(oFbAddr), .iFbData(iFbData),
        .oStart(oStart), .oByteQnty(oByteQnty), .oByteOut(oByteOut), .iByteCnt(mCnt),
        .iAckErr(mErr), .iAction(mAct), .oReady(oReady), .oBusy(oBusy),
        .oFrameDone(oFrameDone), .oFault(oFault)
    );

    logic [7:0] fbMem [FB_BYTES];
    always @(posedge clk) iFbData <= fbMem[oFbAddr];

    logic [7:0] romInit [INIT_LEN] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                       8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                       8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] winCmds [WIN_LEN] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    int nChecks = 0;
    int nErrors = 0;
    logic [7:0] expQ [$];

    int attempts = 0, doneCnt = 0, nackUsed = 0;
    int nackBudget = 0, nackPos = 0;
    int mPhase, mTick, mPos, mQnty;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic sbCheck(input logic [7:0] b);
        logic [7:0] e;
        nChecks++;
        if (expQ.size() == 0) begin
            nErrors++;
            $display("FAIL wire_byte: got %02h, required nothing (no byte expected)", b);
        end else begin
            e = expQ.pop_front();
            if (b !== e) begin
                nErrors++;
                $display("FAIL wire_byte: got %02h, required %02h", b, e);
            end
        end
    endtask

    // i2cWR + slave model; 4 clk per byte, index changes 3 clk before the byte is taken
    initial begin
        logic [7:0] b;
        mAct = 1'b0; mErr = 1'b0; mCnt = '0;
        mPhase = 0; mTick = 0; mPos = 0; mQnty = 0;
        forever begin
            @(negedge clk);
            if (oFrameDone) doneCnt++;
            if (rst) begin
                mAct = 1'b0; mErr = 1'b0; mCnt = '0; mPhase = 0;
            end else begin
                case (mPhase)
                    0: if (oStart) begin
                        mAct = 1'b1; mErr = 1'b0; mCnt = '0;
                        mPos = 0; mTick = 0; mQnty = int'(oByteQnty);
                        attempts++;
                        mPhase = 1;
                    end
                    1: begin
                        if (mTick == 0 && mPos > 0) mCnt = 11'(mPos - 1);
                        if (mTick == 3) begin
                            b = (mPos == 0) ? {OLED_ID, 1'b0} : oByteOut;
                            sbCheck(b);
                            mTick = 0;
                            if (nackUsed < nackBudget && mPos == nackPos) begin
                                mErr = 1'b1; nackUsed++; mPhase = 2;
                            end else if (mPos == mQnty) begin
                                mPhase = 2;
                            end else begin
                                mPos++;
                            end
                        end else begin
                            mTick++;
                        end
                    end
                    default: begin
                        if (mTick == 2) begin
                            mAct = 1'b0; mPhase = 0;
                        end else begin
                            mTick++;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] winByte(input int p);
        if (p == 0) return 8'h78;
        if (p == 1) return 8'h00;
        return winCmds[p-2];
    endfunction

    task automatic pushInit();
        expQ.push_back(8'h78);
        expQ.push_back(8'h00);
        for (int i = 0; i < INIT_LEN; i++) expQ.push_back(romInit[i]);
    endtask

    task automatic pushWin(input int lastPos);
        for (int p = 0; p <= lastPos; p++) expQ.push_back(winByte(p));
    endtask

    task automatic pushData();
        expQ.push_back(8'h78);
        expQ.push_back(8'h40);
        for (int i = 0; i < FB_BYTES; i++) expQ.push_back(fbMem[i]);
    endtask

    task automatic pulseReq();
        @(negedge clk) iFrameReq = 1'b1;
        @(negedge clk) iFrameReq = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        repeat (4) @(negedge clk);
        while (oBusy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_time"}, 32'(n < budget), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_oStart"}, 32'(oStart), 32'd0);
        chk({tag, "_oBusy"}, 32'(oBusy), 32'd0);
        chk({tag, "_oReady"}, 32'(oReady), 32'd0);
        chk({tag, "_oFault"}, 32'(oFault), 32'd0);
        chk({tag, "_oFrameDone"}, 32'(oFrameDone), 32'd0);
        chk({tag, "_oByteOut"}, 32'(oByteOut), 32'd0);
        chk({tag, "_oByteQnty"}, 32'(oByteQnty), 32'd0);
        chk({tag, "_oFbAddr"}, 32'(oFbAddr), 32'd0);
        chk({tag, "_state"}, 32'(dut.state), 32'(ST_PWRUP));
    endtask

    task automatic resetAndInit(input string tag);
        int a0;
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1;
        checkResetOutputs(tag);
        expQ.delete();
        pushInit();
        a0 = attempts;
        @(negedge clk) rst = 1'b0;
        waitIdle({tag, "_init"}, 5000);
        chk({tag, "_init_ready"}, 32'(oReady), 32'd1);
        chk({tag, "_init_attempts"}, 32'(attempts - a0), 32'd1);
        chk({tag, "_init_drained"}, 32'(expQ.size()), 32'd0);
    endtask

    typedef struct {
        string name;
        int    nacks;
        int    nPos;
        int    expAttempts;
        int    expFault;
        int    expDone;
    } row_t;

    row_t rows[4];

    initial begin
        int n, a0, d0, k, starts;
        rows[0] = '{"frame_clean",     0,  0, 2, 0, 1};
        rows[1] = '{"frame_addr_nack2", 2, 0, 4, 0, 1};
        rows[2] = '{"frame_byte_nack1", 1, 3, 3, 0, 1};
        rows[3] = '{"frame_nack_all",  99, 0, 4, 1, 0};
        for (int i = 0; i < FB_BYTES; i++) fbMem[i] = 8'($urandom_range(0, 255));

        // Reset values, power-up delay and the init script
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        pushInit();
        @(negedge clk) rst = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (oStart) break;
        end
        chk("first_start_cycle", 32'(n), 32'(PWRUP_CYC + GAP_CYC));
        chk("init_qnty", 32'(oByteQnty), 32'(INIT_LEN + 1));
        waitIdle("init", 5000);
        chk("init_ready", 32'(oReady), 32'd1);
        chk("init_busy", 32'(oBusy), 32'd0);
        chk("init_attempts", 32'(attempts), 32'd1);
        chk("init_drained", 32'(expQ.size()), 32'd0);

        // Frame refreshes with various NACK patterns
        for (int r = 0; r < 4; r++) begin
            a0 = attempts;
            d0 = doneCnt;
            nackBudget = nackUsed + rows[r].nacks;
            nackPos = rows[r].nPos;
            k = (rows[r].nacks < MAX_RETRY + 1) ? rows[r].nacks : MAX_RETRY + 1;
            for (int i = 0; i < k; i++) pushWin(rows[r].nPos);
            if (rows[r].nacks <= MAX_RETRY) begin
                pushWin(WIN_LEN + 1);
                pushData();
            end
            pulseReq();
            waitIdle(rows[r].name, 20000);
            chk({rows[r].name, "_attempts"}, 32'(attempts - a0), 32'(rows[r].expAttempts));
            chk({rows[r].name, "_frame_done"}, 32'(doneCnt - d0), 32'(rows[r].expDone));
            chk({rows[r].name, "_fault"}, 32'(oFault), 32'(rows[r].expFault));
            chk({rows[r].name, "_busy"}, 32'(oBusy), 32'd0);
            chk({rows[r].name, "_retry"}, 32'(dut.retry), (rows[r].expFault != 0) ? 32'(MAX_RETRY) : 32'd0);
            chk({rows[r].name, "_drained"}, 32'(expQ.size()), 32'd0);
        end
        nackBudget = nackUsed;

        // FAULT is sticky: no further starts, requests ignored
        a0 = attempts;
        starts = 0;
        repeat (200) @(negedge clk) if (oStart) starts++;
        pulseReq();
        repeat (2000) @(negedge clk) if (oStart) starts++;
        chk("fault_no_start", 32'(starts), 32'd0);
        chk("fault_no_attempt", 32'(attempts - a0), 32'd0);
        chk("fault_sticky", 32'(oFault), 32'd1);
        chk("fault_req_dropped", 32'(dut.pending), 32'd0);

        // Several requests during one frame coalesce into a single extra frame
        resetAndInit("coalesce");
        a0 = attempts;
        d0 = doneCnt;
        pushWin(WIN_LEN + 1); pushData();
        pushWin(WIN_LEN + 1); pushData();
        pulseReq();
        repeat (300) @(negedge clk);
        pulseReq();
        repeat (300) @(negedge clk);
        pulseReq();
        repeat (300) @(negedge clk);
        pulseReq();
        waitIdle("coalesce", 30000);
        chk("coalesce_attempts", 32'(attempts - a0), 32'd4);
        chk("coalesce_frame_done", 32'(doneCnt - d0), 32'd2);
        chk("coalesce_drained", 32'(expQ.size()), 32'd0);

        // Reset in the middle of the data stream aborts and resends the init script
        pushWin(WIN_LEN + 1);
        pushData();
        pulseReq();
        n = 0;
        while (!(mPhase == 1 && mQnty == FB_BYTES + 1 && mCnt == 11'd500) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_data_reached", 32'(n < 10000), 32'd1);
        resetAndInit("rst_mid");
        chk("rst_mid_busy", 32'(oBusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
